// File: rtl/vga_timing_pkg.sv
// Shared timing constants, counter widths, FSM encoding and saturating
// helpers for the sync-only VGA decoder. Defaults describe 1280x1024@60.
package vga_timing_pkg;

    localparam int DEF_H_SYNC      = 112;
    localparam int DEF_H_BACK      = 248;
    localparam int DEF_H_ACTIVE    = 1280;
    localparam int DEF_H_TOTAL     = 1688;
    localparam int DEF_V_SYNC      = 3;
    localparam int DEF_V_BACK      = 38;
    localparam int DEF_V_ACTIVE    = 1024;
    localparam int DEF_V_TOTAL     = 1066;
    localparam int DEF_SYNC_POS    = 1;
    localparam int DEF_LOCK_FRAMES = 2;

    localparam int HCNT_W   = 12;
    localparam int VCNT_W   = 11;
    localparam int GOOD_W   = 4;
    localparam int ERRCNT_W = 16;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } dec_state_e;

    // Horizontal counter increment that sticks at all-ones.
    function automatic logic [HCNT_W-1:0] sat_inc_h(input logic [HCNT_W-1:0] v);
        logic [HCNT_W-1:0] res;
        if (v == {HCNT_W{1'b1}}) begin
            res = v;
        end else begin
            res = v + 12'd1;
        end
        return res;
    endfunction

    // Vertical counter increment that sticks at all-ones.
    function automatic logic [VCNT_W-1:0] sat_inc_v(input logic [VCNT_W-1:0] v);
        logic [VCNT_W-1:0] res;
        if (v == {VCNT_W{1'b1}}) begin
            res = v;
        end else begin
            res = v + 11'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Two-flop synchronizer, polarity normalisation and assertion-edge pulse
// for one sync input. o_edge is high for one cycle when the normalised sync
// level goes from inactive to active.
module vga_sync_edge #(
    parameter int SYNC_POS = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sync,
    output logic o_edge
);

    localparam logic ACT_LVL  = (SYNC_POS != 0);
    localparam logic IDLE_LVL = ~ACT_LVL;

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic w_norm;

    assign w_norm = (r_sync == ACT_LVL);
    assign o_edge = w_norm & ~r_prev;

    // Synchronize the raw sync and remember the previous normalised level.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= IDLE_LVL;
            r_sync <= IDLE_LVL;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_sync;
            r_sync <= r_meta;
            r_prev <= w_norm;
        end
    end

endmodule

// File: rtl/vga_sync_decoder.sv
// Sync-only VGA receiver: recovers pixel coordinates from HS/VS, measures
// line and frame lengths, and tracks lock against the expected timing.
// Optional feature macro: VGA_DEC_ERRCNT_EN adds a saturating err_count port.
module vga_sync_decoder
    import vga_timing_pkg::*;
#(
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BACK      = DEF_H_BACK,
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int H_TOTAL     = DEF_H_TOTAL,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BACK      = DEF_V_BACK,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int V_TOTAL     = DEF_V_TOTAL,
    parameter int SYNC_POS    = DEF_SYNC_POS,
    parameter int LOCK_FRAMES = DEF_LOCK_FRAMES
) (
    input  logic        CLOCK_50,
    input  logic        RESET,
    input  logic        VGA_HS,
    input  logic        VGA_VS,
    output logic [10:0] XPixelPosition,
    output logic [10:0] YPixelPosition,
    output logic        active,
    output logic        frame_start,
    output logic        locked,
    output logic        sync_error,
    output logic [11:0] line_len,
    output logic [10:0] frame_lines
`ifdef VGA_DEC_ERRCNT_EN
    ,
    output logic [15:0] err_count
`endif
);

    localparam logic [HCNT_W-1:0] H_START = 12'(H_SYNC + H_BACK);
    localparam logic [HCNT_W-1:0] H_END   = 12'(H_SYNC + H_BACK + H_ACTIVE - 1);
    localparam logic [HCNT_W-1:0] H_LEN   = 12'(H_TOTAL);
    localparam logic [VCNT_W-1:0] V_START = 11'(V_SYNC + V_BACK);
    localparam logic [VCNT_W-1:0] V_END   = 11'(V_SYNC + V_BACK + V_ACTIVE - 1);
    localparam logic [VCNT_W-1:0] V_LEN   = 11'(V_TOTAL);
    localparam logic [GOOD_W-1:0] GOOD_TARGET = 4'(LOCK_FRAMES);

    logic               w_hs_edge;
    logic               w_vs_edge;

    dec_state_e         r_state;
    dec_state_e         w_state_nxt;
    logic [HCNT_W-1:0]  r_hcnt;
    logic [VCNT_W-1:0]  r_vcnt;
    logic [GOOD_W-1:0]  r_good;
    logic [GOOD_W-1:0]  w_good_nxt;
    logic               r_clean;
    logic               w_clean_nxt;
    logic               r_h_seen;
    logic               w_h_seen_nxt;

    logic [HCNT_W-1:0]  w_hcnt_inc;
    logic [HCNT_W-1:0]  w_hcnt_nxt;
    logic [VCNT_W-1:0]  w_vcnt_hs;
    logic [VCNT_W-1:0]  w_vcnt_nxt;
    logic               w_line_bad;
    logic               w_frame_bad;
    logic               w_wd_bad;
    logic               w_mismatch;
    logic               w_active;
    logic [HCNT_W-1:0]  w_hdiff;
    logic [VCNT_W-1:0]  w_vdiff;

    logic [10:0]        r_x;
    logic [10:0]        r_y;
    logic               r_active;
    logic               r_frame_start;
    logic               r_locked;
    logic               r_sync_error;
    logic [11:0]        r_line_len;
    logic [10:0]        r_frame_lines;

    vga_sync_edge #(.SYNC_POS(SYNC_POS)) u_hs_edge (
        .i_clk  (CLOCK_50),
        .i_rst  (RESET),
        .i_sync (VGA_HS),
        .o_edge (w_hs_edge)
    );

    vga_sync_edge #(.SYNC_POS(SYNC_POS)) u_vs_edge (
        .i_clk  (CLOCK_50),
        .i_rst  (RESET),
        .i_sync (VGA_VS),
        .o_edge (w_vs_edge)
    );

    // Next horizontal/vertical counts; a VS edge clears vcnt even when an HS edge coincides.
    always_comb begin
        w_hcnt_inc = sat_inc_h(r_hcnt);
        w_hcnt_nxt = w_hcnt_inc;
        w_vcnt_hs  = r_vcnt;
        w_vcnt_nxt = r_vcnt;
        if (w_hs_edge) begin
            w_hcnt_nxt = 12'd0;
            w_vcnt_hs  = sat_inc_v(r_vcnt);
        end else begin
            w_hcnt_nxt = w_hcnt_inc;
            w_vcnt_hs  = r_vcnt;
        end
        if (w_vs_edge) begin
            w_vcnt_nxt = 11'd0;
        end else begin
            w_vcnt_nxt = w_vcnt_hs;
        end
    end

    // Line, frame and lost-HS checks; the first HS edge after SEARCH only starts counting.
    always_comb begin
        w_line_bad  = w_hs_edge && r_h_seen &&
                      ((r_hcnt == 12'hFFF) || (w_hcnt_inc != H_LEN));
        w_frame_bad = w_vs_edge && (r_state != ST_SEARCH) && (w_vcnt_hs != V_LEN);
        w_wd_bad    = (r_hcnt == 12'hFFE) && !w_hs_edge;
        w_mismatch  = w_line_bad || w_frame_bad || w_wd_bad;
    end

    // Lock FSM: count clean frames in ACQUIRE, drop to SEARCH on any error while LOCKED.
    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good;
        w_clean_nxt = r_clean;
        case (r_state)
            ST_SEARCH: begin
                if (w_vs_edge) begin
                    w_state_nxt = ST_ACQUIRE;
                    w_good_nxt  = 4'd0;
                    w_clean_nxt = 1'b1;
                end else begin
                    w_state_nxt = ST_SEARCH;
                end
            end
            ST_ACQUIRE: begin
                if (w_vs_edge) begin
                    w_clean_nxt = 1'b1;
                    if (r_clean && !w_mismatch) begin
                        w_good_nxt = r_good + 4'd1;
                        if ((r_good + 4'd1) == GOOD_TARGET) begin
                            w_state_nxt = ST_LOCKED;
                        end else begin
                            w_state_nxt = ST_ACQUIRE;
                        end
                    end else begin
                        w_good_nxt = 4'd0;
                    end
                end else if (w_mismatch) begin
                    w_good_nxt  = 4'd0;
                    w_clean_nxt = 1'b0;
                end else begin
                    w_state_nxt = ST_ACQUIRE;
                end
            end
            ST_LOCKED: begin
                if (w_mismatch) begin
                    w_state_nxt = ST_SEARCH;
                end else begin
                    w_state_nxt = ST_LOCKED;
                end
            end
            default: begin
                w_state_nxt = ST_SEARCH;
            end
        endcase
    end

    // Track whether an HS edge has been seen since (re)entering SEARCH.
    always_comb begin
        if ((w_state_nxt == ST_SEARCH) && (r_state != ST_SEARCH)) begin
            w_h_seen_nxt = 1'b0;
        end else if (w_hs_edge) begin
            w_h_seen_nxt = 1'b1;
        end else begin
            w_h_seen_nxt = r_h_seen;
        end
    end

    // Active-area decode and coordinates for the sample being processed.
    always_comb begin
        w_active = (w_hcnt_nxt >= H_START) && (w_hcnt_nxt <= H_END) &&
                   (w_vcnt_nxt >= V_START) && (w_vcnt_nxt <= V_END);
        if (w_active) begin
            w_hdiff = w_hcnt_nxt - H_START;
            w_vdiff = w_vcnt_nxt - V_START;
        end else begin
            w_hdiff = 12'd0;
            w_vdiff = 11'd0;
        end
    end

    // FSM state, position counters and lock bookkeeping.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_state  <= ST_SEARCH;
            r_hcnt   <= 12'd0;
            r_vcnt   <= 11'd0;
            r_good   <= 4'd0;
            r_clean  <= 1'b0;
            r_h_seen <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_hcnt   <= w_hcnt_nxt;
            r_vcnt   <= w_vcnt_nxt;
            r_good   <= w_good_nxt;
            r_clean  <= w_clean_nxt;
            r_h_seen <= w_h_seen_nxt;
        end
    end

    // Registered outputs; locked follows the registered state one cycle later.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_x           <= 11'd0;
            r_y           <= 11'd0;
            r_active      <= 1'b0;
            r_frame_start <= 1'b0;
            r_locked      <= 1'b0;
            r_sync_error  <= 1'b0;
            r_line_len    <= 12'd0;
            r_frame_lines <= 11'd0;
        end else begin
            r_x           <= w_hdiff[10:0];
            r_y           <= w_vdiff;
            r_active      <= w_active;
            r_frame_start <= w_vs_edge;
            r_locked      <= (r_state == ST_LOCKED);
            r_sync_error  <= w_mismatch;
            r_line_len    <= w_hs_edge ? w_hcnt_inc : r_line_len;
            r_frame_lines <= w_vs_edge ? w_vcnt_hs : r_frame_lines;
        end
    end

    assign XPixelPosition = r_x;
    assign YPixelPosition = r_y;
    assign active         = r_active;
    assign frame_start    = r_frame_start;
    assign locked         = r_locked;
    assign sync_error     = r_sync_error;
    assign line_len       = r_line_len;
    assign frame_lines    = r_frame_lines;

`ifdef VGA_DEC_ERRCNT_EN
    logic [15:0] r_err_count;

    // Saturating count of sync errors, cleared only by RESET.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_err_count <= 16'd0;
        end else if (w_mismatch && (r_err_count != 16'hFFFF)) begin
            r_err_count <= r_err_count + 16'd1;
        end else begin
            r_err_count <= r_err_count;
        end
    end

    assign err_count = r_err_count;
`endif

endmodule
